// File: rtl/clock_pkg.sv
// Shared types, field limits and helpers for the time-of-day controller.
// BCD ordering matches binary ordering for valid digits, so limits compare directly.
package clock_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_e;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;
  localparam logic [7:0] CC_MAX = 8'h99;

  localparam int H = 3;
  localparam int M = 2;
  localparam int S = 1;
  localparam int C = 0;

  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter wrapping at max; load beats inc. Carry is combinational so a
// whole chain of fields rolls over in one cycle. Latency 1 clk, no backpressure.
module bcd_field_counter
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] max,
  output logic [7:0] val,
  output logic       carry
);

  logic [7:0] val_q, val_d;
  logic       at_max;

  assign at_max = (val_q == max);
  assign carry  = inc & ~load & at_max;
  assign val    = val_q;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (inc) begin
      if (at_max) begin
        val_d = 8'h00;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day controller: synchronised set switches, RUN/SET FSM, prescaled BCD cascade,
// range-checked field loads and blink mask. Switch edge to time_out is 4 clk; no backpressure.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 100,
  parameter int BLINK_TICKS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  time_in,
  input  logic        set_hour,
  input  logic        set_minute,
  input  logic        set_second,
  input  logic        set_mil,
  output logic [31:0] time_out,
  output logic [3:0]  blank_mask,
  output logic        tick,
  output logic        day_wrap,
  output logic        load_err
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [3:0]    sw_raw;
  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, ld_q, ld_d;
  logic [3:0]    rise, ld_ok, fld_load;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d, bdiv_q, bdiv_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          tick_q, tick_d, day_wrap_q, day_wrap_d, load_err_q, load_err_d;
  logic          tick_inc, blink_stb;
  logic          carry_c, carry_s, carry_m, carry_h;
  logic [7:0]    hh, mm, ss, cc;

  assign sw_raw = {set_hour, set_minute, set_second, set_mil};

  // A rise is registered once more before it loads, so the load sees the settled SET state.
  always_comb begin
    sync1_d   = sw_raw;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    rise      = sync2_q & ~prev_q;
    ld_d      = rise;
    state_d   = state_q;
    presc_d   = '0;
    bdiv_d    = '0;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    tick_inc  = 1'b0;
    blink_stb = 1'b0;
    case (state_q)
      RUN: begin
        if (|sync2_q) state_d = SET;
        if (presc_q == DIV_LAST) begin
          tick_inc = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        bcnt_d  = '0;
        phase_d = 1'b0;
      end
      SET: begin
        if (~|sync2_q) state_d = RUN;
        if (bdiv_q == DIV_LAST) begin
          blink_stb = 1'b1;
        end else begin
          bdiv_d = bdiv_q + 1'b1;
        end
        if (blink_stb) begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
    tick_d = tick_inc;
  end

  // Every rising field checks the shared load value against its own limit.
  always_comb begin
    ld_ok      = '0;
    ld_ok[H]   = bcd_valid(time_in, HH_MAX);
    ld_ok[M]   = bcd_valid(time_in, MS_MAX);
    ld_ok[S]   = bcd_valid(time_in, MS_MAX);
    ld_ok[C]   = bcd_valid(time_in, CC_MAX);
    fld_load   = ld_q & ld_ok;
    load_err_d = |(ld_q & ~ld_ok);
  end

  assign day_wrap_d = carry_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      ld_q       <= '0;
      state_q    <= RUN;
      presc_q    <= '0;
      bdiv_q     <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      ld_q       <= ld_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      bdiv_q     <= bdiv_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  bcd_field_counter u_cc (
    .clk(clk), .rst_n(rst_n), .inc(tick_inc), .load(fld_load[C]),
    .load_val(time_in), .max(CC_MAX), .val(cc), .carry(carry_c)
  );

  bcd_field_counter u_ss (
    .clk(clk), .rst_n(rst_n), .inc(carry_c), .load(fld_load[S]),
    .load_val(time_in), .max(MS_MAX), .val(ss), .carry(carry_s)
  );

  bcd_field_counter u_mm (
    .clk(clk), .rst_n(rst_n), .inc(carry_s), .load(fld_load[M]),
    .load_val(time_in), .max(MS_MAX), .val(mm), .carry(carry_m)
  );

  bcd_field_counter u_hh (
    .clk(clk), .rst_n(rst_n), .inc(carry_m), .load(fld_load[H]),
    .load_val(time_in), .max(HH_MAX), .val(hh), .carry(carry_h)
  );

  assign time_out   = {hh, mm, ss, cc};
  assign blank_mask = sync2_q & {4{phase_q}};
  assign tick       = tick_q;
  assign day_wrap   = day_wrap_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl at DIV=10, BLINK_TICKS=2: table of field loads with a scoreboard,
// plus hand sequences for tick timing, day rollover, blink and asynchronous reset.
module tb_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  time_in;
  logic        set_hour, set_minute, set_second, set_mil;
  logic [31:0] time_out;
  logic [3:0]  blank_mask;
  logic        tick, day_wrap, load_err;

  always #5 clk = ~clk;

  clock_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .BLINK_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .time_in(time_in),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second), .set_mil(set_mil),
    .time_out(time_out), .blank_mask(blank_mask), .tick(tick),
    .day_wrap(day_wrap), .load_err(load_err)
  );

  typedef struct {
    logic [3:0]  sw;
    logic [7:0]  din;
    logic        err;
    logic [31:0] t;
  } vec_t;

  typedef struct {
    logic [31:0] t;
    logic        err;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_sw(input logic [3:0] sw);
    {set_hour, set_minute, set_second, set_mil} = sw;
  endtask

  // Press, let the load land 4 clk later, release; ends with the FSM just back in RUN.
  task automatic press(input int i);
    exp_t e;
    e.t   = vecs[i].t;
    e.err = vecs[i].err;
    time_in = vecs[i].din;
    sb.push_back(e);
    drive_sw(vecs[i].sw);
    step(3);
    chk("load_err_early", 32'(load_err), 32'd0);
    step(1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("time_out v%0d", i), time_out, e.t);
      chk($sformatf("load_err v%0d", i), 32'(load_err), 32'(e.err));
    end
    drive_sw(4'b0000);
    step(1);
    chk("load_err_one_cycle", 32'(load_err), 32'd0);
    step(2);
  endtask

  initial begin
    int ticks;
    logic [3:0] em;

    vecs[0]  = '{4'b1000, 8'h23, 1'b0, 32'h23000000};
    vecs[1]  = '{4'b0100, 8'h59, 1'b0, 32'h23590000};
    vecs[2]  = '{4'b0010, 8'h59, 1'b0, 32'h23595900};
    vecs[3]  = '{4'b0001, 8'h99, 1'b0, 32'h23595999};
    vecs[4]  = '{4'b0100, 8'h60, 1'b1, 32'h00000000};
    vecs[5]  = '{4'b0100, 8'h5A, 1'b1, 32'h00000000};
    vecs[6]  = '{4'b0100, 8'h42, 1'b0, 32'h00420000};
    vecs[7]  = '{4'b1010, 8'h30, 1'b1, 32'h00423000};
    vecs[8]  = '{4'b0001, 8'hA0, 1'b1, 32'h00423000};
    vecs[9]  = '{4'b1000, 8'h24, 1'b1, 32'h00423000};
    vecs[10] = '{4'b1000, 8'h19, 1'b0, 32'h19423000};
    vecs[11] = '{4'b1000, 8'h12, 1'b0, 32'h12423001};
    vecs[12] = '{4'b0100, 8'h34, 1'b0, 32'h12343001};
    vecs[13] = '{4'b0010, 8'h56, 1'b0, 32'h12345601};
    vecs[14] = '{4'b0001, 8'h78, 1'b0, 32'h12345678};

    rst_n   = 1'b0;
    time_in = 8'h00;
    drive_sw(4'b0000);
    step(2);
    chk("rst time_out", time_out, 32'h0);
    chk("rst blank_mask", 32'(blank_mask), 32'h0);
    chk("rst tick", 32'(tick), 32'h0);
    chk("rst day_wrap", 32'(day_wrap), 32'h0);
    chk("rst load_err", 32'(load_err), 32'h0);

    // Free-running: first tick on clk 10, 100 ticks reach 00:00:01.00.
    rst_n = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 1000; k++) begin
      step(1);
      if (tick) ticks++;
      if (k <= 10) chk($sformatf("first_tick k%0d", k), 32'(tick), 32'(k == 10));
      if (k == 999) chk("time_out k999", time_out, 32'h00000099);
    end
    chk("time_out 100 ticks", time_out, 32'h00000100);
    chk("tick count", 32'(ticks), 32'd100);

    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i <= 3; i++) press(i);

    // 23:59:59.99 rolls over DIV clk after returning to RUN.
    step(9);
    chk("pre_wrap time", time_out, 32'h23595999);
    chk("pre_wrap tick", 32'(tick), 32'd0);
    step(1);
    chk("wrap time", time_out, 32'h00000000);
    chk("wrap tick", 32'(tick), 32'd1);
    chk("wrap day_wrap", 32'(day_wrap), 32'd1);
    step(1);
    chk("post_wrap day_wrap", 32'(day_wrap), 32'd0);
    chk("post_wrap tick", 32'(tick), 32'd0);

    for (int i = 4; i <= 10; i++) press(i);

    // Held switch: one load, blink every 20 clk, time frozen.
    time_in = 8'h30;
    drive_sw(4'b0010);
    for (int k = 1; k <= 200; k++) begin
      step(1);
      em = ((k >= 3) && ((((k - 3) / 20) % 2) == 1)) ? 4'b0010 : 4'b0000;
      chk($sformatf("blink k%0d", k), 32'(blank_mask), 32'(em));
      if (k == 4) chk("hold load_err", 32'(load_err), 32'd0);
      if (k == 100) time_in = 8'h11;
    end
    chk("hold frozen", time_out, 32'h19423000);
    drive_sw(4'b0000);
    for (int j = 1; j <= 13; j++) begin
      step(1);
      if (j >= 2) chk($sformatf("release mask j%0d", j), 32'(blank_mask), 32'd0);
      chk($sformatf("release tick j%0d", j), 32'(tick), 32'(j == 13));
    end
    chk("release first inc", time_out, 32'h19423001);

    for (int i = 11; i <= 14; i++) press(i);

    // Asynchronous reset mid-prescaler clears outputs before the next edge.
    step(5);
    chk("pre_reset time", time_out, 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async time_out", time_out, 32'h0);
    chk("async blank_mask", 32'(blank_mask), 32'h0);
    chk("async tick", 32'(tick), 32'h0);
    chk("async day_wrap", 32'(day_wrap), 32'h0);
    chk("async load_err", 32'(load_err), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Timekeeping controller for the clock display path. Owns the running time-of-day as packed BCD HH:MM:SS:CC, where CC is hundredths. Sequences run and set modes from the set_hour/set_minute/set_second/set_mil switches and loads fields from time_in. Drives time_out straight into seven_seg_driver, plus a per-field blink mask for the field being set.

Parameters:
CLK_HZ, 50000000, input clock frequency
TICK_HZ, 100, count rate of the CC field; prescaler divide DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an integer multiple of TICK_HZ
BLINK_TICKS, 25, CC ticks per blink half-period (25 gives 2 Hz)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous, active-low reset
time_in  in  8  two-digit BCD load value {tens, ones}
set_hour  in  1  switch level, asynchronous to clk
set_minute  in  1  switch level, asynchronous to clk
set_second  in  1  switch level, asynchronous to clk
set_mil  in  1  switch level, asynchronous to clk
time_out  out  32  BCD {HH[31:24], MM[23:16], SS[15:8], CC[7:0]}, registered
blank_mask  out  4  {H, M, S, C}; 1 = blank that field's digits this cycle
tick  out  1  one-cycle pulse on every CC increment
day_wrap  out  1  one-cycle pulse on the 23:59:59.99 -> 00:00:00.00 rollover
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (asynchronous, rst_n=0): time_out=32'h0, blank_mask=0, tick=0, day_wrap=0, load_err=0, prescaler=0, FSM=RUN, synchronizer and edge flops=0.
- Each set_* goes through a 2-flop synchronizer, then a registered previous-value flop. rise_x = sync_x & ~prev_x.
- FSM states: RUN and SET.
  - RUN -> SET when any synchronized set_* = 1.
  - SET -> RUN when all synchronized set_* = 0, on the next clk.
- RUN:
  - Prescaler counts 0..DIV-1. At DIV-1: prescaler -> 0, tick=1, CC increments.
  - Cascade: CC 99->00 carries to SS; SS 59->00 carries to MM; MM 59->00 carries to HH; HH 23->00.
  - Every carry in the chain takes effect in the same cycle. day_wrap=1 only when all four fields wrap in the same cycle.
- SET:
  - Prescaler held at 0, no ticks, time frozen.
  - On rise_x, field x loads time_in in the following cycle.
  - Load is accepted only if both nibbles are ≤ 9 and the value is ≤ limit: HH ≤ 23, MM ≤ 59, SS ≤ 59, CC ≤ 99.
  - On rejection: the field is unchanged and load_err=1 for one cycle.
  - Simultaneous rises: each rising field loads the same time_in independently, each range-checked against its own limit. load_err=1 if any of them is rejected.
  - A set_* held high causes one load only; reloading needs a release and a new press.
- Latency: set_* pin edge to time_out updated is 4 clk (2 sync + edge register + load register).
- Blink:
  - A blink counter advances on tick-rate strobes generated in SET. The prescaler runs a separate blink divider in SET, also at DIV; the time fields do not advance.
  - blank_mask[x] = sync_x & blink_phase. blink_phase toggles every BLINK_TICKS strobes and is 0 on entering SET.
  - In RUN, blank_mask=0 and the blink counter is cleared.
- Leaving SET: the first CC increment occurs exactly DIV clk after the FSM reaches RUN.
- Reset during SET or mid-carry: immediate return to reset values. No partial field survives.
- time_out digits are always valid BCD. No out-of-range state is reachable.

Decomposition:
- Shared package clock_pkg contains:
  - state enum {RUN, SET}
  - field limits HH_MAX=8'h23, MS_MAX=8'h59, CC_MAX=8'h99
  - field index constants H=3, M=2, S=1, C=0
  - a function bcd_valid(value, max)
- One sub-module, bcd_field_counter, instantiated four times. Each instance has:
  - inputs: clk, rst_n, inc, load, load_val[7:0], max[7:0]
  - outputs: val[7:0], carry (inc at max; val wraps to 00)
  - load takes priority over inc
- clock_ctrl holds the synchronizers, prescaler, FSM, blink logic and range check.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10, BLINK_TICKS=2):
1. Release reset with all set_* = 0 -> time_out=0 and the first tick occurs at clk 10. After 100 ticks, time_out=32'h00000100.
2. In SET, load 8'h23 into HH, 8'h59 into MM and SS, 8'h99 into CC, then release the switches -> after DIV clk, time_out=32'h00000000 with day_wrap=1 and tick=1 in the same cycle.
3. Pulse set_minute with time_in=8'h60, then time_in=8'h5A -> MM unchanged and load_err pulses twice. Then time_in=8'h42 -> MM=8'h42 and load_err=0.
4. Raise set_hour and set_second together with time_in=8'h30 -> SS=8'h30, HH unchanged, load_err=1 for one cycle.
5. Hold set_second high for 200 clk -> blank_mask toggles between 4'b0000 and 4'b0010 every 20 clk and time_out stays frozen. After release, blank_mask=0 and the next tick comes at +10 clk.
6. Assert rst_n=0 asynchronously mid-prescaler with time 12:34:56.78 -> all outputs 0 immediately, before the next clk edge.
